data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-organised data RAM directly downstream of the ALU. The ALU result is the byte address for loads and stores.
- Supports byte, halfword and word accesses, with sign or zero extension on loads.
- Reads are combinational, so the single-cycle datapath can write back in the same cycle. Stores commit on the clock edge.
- Detects bad accesses, suppresses them, and records the first one in sticky fault registers for debug/exception logic.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words (power of two, 4..4096)
ADDR_BITS, 8, log2(DEPTH_WORDS); word index is addr[ADDR_BITS+1:2]

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
addr  input  32  byte address (ALU result)
wdata  input  32  store data; low bits used for byte/half stores
mem_read  input  1  load request this cycle
mem_write  input  1  store request this cycle
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
load_unsigned  input  1  1 = zero-extend byte/half loads, 0 = sign-extend
fault_clear  input  1  clears sticky fault registers
rdata  output  32  load result (combinational)
access_fault  output  1  combinational: current access is bad
fault_sticky  output  1  registered: a fault has been captured
fault_cause  output  2  registered: 01 misaligned, 10 out of range, 11 bad size
fault_addr  output  32  registered: address of captured fault

Behaviour:
- Little-endian byte lanes: byte k of a word occupies bits [8k+7:8k].
- Access is active when mem_read | mem_write.
- Fault classification (active access only), priority bad size > out of range > misaligned:
  - bad size: size==11.
  - out of range: addr[31:ADDR_BITS+2] != 0.
  - misaligned: half with addr[0]==1, or word with addr[1:0]!=0.
- access_fault = active & any fault; combinational, same cycle.
- Load (mem_read=1, no fault), selected bits extended per load_unsigned:
  - byte: lane addr[1:0].
  - half: lanes {addr[1],1} and {addr[1],0}, i.e. bits [15:0] or [31:16].
  - word: full word.
- rdata = 0 when mem_read=0 or access_fault=1.
- Store (mem_write=1, no fault, rst=0): only the addressed lanes are written at the rising edge; other lanes are unchanged.
  - byte: wdata[7:0].
  - half: wdata[15:0].
  - word: wdata.
- Faulting stores write nothing.
- Read and write in the same cycle to the same word: rdata shows the pre-edge contents (no write-through). The new data is visible the cycle after the edge.
- Sticky fault logic, per rising edge, evaluated in this order:
  - If rst: fault_sticky=0, fault_cause=00, fault_addr=0.
  - Else if fault_clear: clear all three, then apply the capture rule below in the same edge (a simultaneous new fault is captured).
  - Capture rule: if access_fault and the sticky register is empty (after any clear), latch the cause and addr and set fault_sticky.
  - Later faults while sticky=1 are ignored; the first fault is preserved.
- Reset:
  - Every memory word is cleared to 0 at the reset edge.
  - Outputs after reset: fault_sticky=0, fault_cause=00, fault_addr=0. rdata and access_fault follow inputs combinationally (0 when idle).
- Stores and fault capture are suppressed while rst=1, even if requested in that cycle.
- No latency beyond the single-cycle write; there is no handshake and no stall.

Test Plan:
- Word store/load:
  - Stimulus: rst 1 cycle; store word 0xDEADBEEF at 0x10; next cycle load word at 0x10.
  - Required: rdata=0xDEADBEEF, access_fault=0.
- Byte/half lanes and extension:
  - Stimulus: after the above, store byte 0x80 at 0x11; then load byte 0x11 signed, then unsigned; then load half 0x12 signed.
  - Required: 0xFFFFFF80, 0x00000080, 0xFFFFDEAD; word at 0x10 reads 0xDEAD80EF.
- Misaligned store suppressed:
  - Stimulus: store word 0x12345678 at 0x22.
  - Required: access_fault=1 that cycle; word 0x20 unchanged (0); next cycle fault_sticky=1, fault_cause=01, fault_addr=0x22.
- Priority and first-fault hold:
  - Stimulus: with sticky set, load size=11 at 0x4003.
  - Required: access_fault=1 but sticky regs unchanged.
  - Stimulus: then assert fault_clear alone.
  - Required: all cleared next cycle.
  - Stimulus: then assert fault_clear together with a load at 0x400 (out of range for 256 words).
  - Required: cause=10, addr=0x400.
- Same-cycle read/write:
  - Stimulus: load and store word 0xA5A5A5A5 at 0x30 (previously 0).
  - Required: rdata=0 that cycle, 0xA5A5A5A5 next cycle.
- Reset mid-operation:
  - Stimulus: store at 0x40 with rst=1 in the same cycle.
  - Required: word 0x40 reads 0 afterwards; all previously written words read 0; fault registers 0.

Source files
------------

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Word-organised data RAM that sits directly behind the ALU. Supports byte,
// halfword and word loads/stores with sign or zero extension on loads.
// Reads are combinational, so the single-cycle datapath can write back in the
// same cycle. Stores commit on the rising edge. Bad accesses (reserved size,
// out-of-range address, misalignment) are suppressed. The first one is held
// in sticky fault registers until it is cleared or the block is reset.
// ----------------------------------------------------------------------------
module data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_BITS   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  size,
   input  logic        load_unsigned,
   input  logic        fault_clear,
   output logic [31:0] rdata,
   output logic        access_fault,
   output logic        fault_sticky,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_addr
);

   // Access size encodings
   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // Fault cause encodings (00 means no fault)
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE    = 2'b10;
   localparam logic [1:0] CAUSE_SIZE     = 2'b11;

   localparam int HIGH_BITS = 30 - ADDR_BITS;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // Extend an 8-bit load value to 32 bits.
   function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic uns);
      logic [31:0] r;
      if (uns) begin
         r = {24'h000000, b};
      end else begin
         r = {{24{b[7]}}, b};
      end
      return r;
   endfunction

   // Extend a 16-bit load value to 32 bits.
   function automatic logic [31:0] extend_half(input logic [15:0] h, input logic uns);
      logic [31:0] r;
      if (uns) begin
         r = {16'h0000, h};
      end else begin
         r = {{16{h[15]}}, h};
      end
      return r;
   endfunction

   // Pick and extend the addressed lanes of a stored word.
   function automatic logic [31:0] load_select(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane,
                                               input logic        uns);
      logic [31:0] r;
      case (sz)
         SIZE_BYTE: begin
            case (lane)
               2'b00:   r = extend_byte(w[7:0],   uns);
               2'b01:   r = extend_byte(w[15:8],  uns);
               2'b10:   r = extend_byte(w[23:16], uns);
               2'b11:   r = extend_byte(w[31:24], uns);
               default: r = 32'h0000_0000;
            endcase
         end
         SIZE_HALF: begin
            if (lane[1]) begin
               r = extend_half(w[31:16], uns);
            end else begin
               r = extend_half(w[15:0], uns);
            end
         end
         SIZE_WORD: r = w;
         default:   r = 32'h0000_0000;
      endcase
      return r;
   endfunction

   // Merge store data into the old word, touching only the addressed lanes.
   function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  lane);
      logic [31:0] r;
      r = old_w;
      case (sz)
         SIZE_BYTE: begin
            case (lane)
               2'b00:   r[7:0]   = wd[7:0];
               2'b01:   r[15:8]  = wd[7:0];
               2'b10:   r[23:16] = wd[7:0];
               2'b11:   r[31:24] = wd[7:0];
               default: r = old_w;
            endcase
         end
         SIZE_HALF: begin
            if (lane[1]) begin
               r[31:16] = wd[15:0];
            end else begin
               r[15:0] = wd[15:0];
            end
         end
         SIZE_WORD: r = wd;
         default:   r = old_w;
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Storage and decode
   // ------------------------------------------------------------------------
   logic [31:0]          mem_r [DEPTH_WORDS];
   logic [ADDR_BITS-1:0] word_idx_s;
   logic [1:0]           lane_s;
   logic [31:0]          word_s;
   logic                 active_s;
   logic                 bad_size_s;
   logic                 out_of_range_s;
   logic                 misaligned_s;
   logic [1:0]           cause_s;
   logic [31:0]          store_word_s;
   logic                 store_en_s;
   logic                 capture_s;

   assign word_idx_s = addr[ADDR_BITS+1:2];
   assign lane_s     = addr[1:0];
   assign word_s     = mem_r[word_idx_s];

   // Classify the current access and pick the highest-priority fault cause.
   always_comb begin
      active_s       = mem_read | mem_write;
      bad_size_s     = (size == 2'b11);
      out_of_range_s = (addr[31:ADDR_BITS+2] != {HIGH_BITS{1'b0}});
      case (size)
         SIZE_HALF: misaligned_s = addr[0];
         SIZE_WORD: misaligned_s = (addr[1:0] != 2'b00);
         default:   misaligned_s = 1'b0;
      endcase
      if (!active_s) begin
         cause_s = CAUSE_NONE;
      end else if (bad_size_s) begin
         cause_s = CAUSE_SIZE;
      end else if (out_of_range_s) begin
         cause_s = CAUSE_RANGE;
      end else if (misaligned_s) begin
         cause_s = CAUSE_MISALIGN;
      end else begin
         cause_s = CAUSE_NONE;
      end
      access_fault = (cause_s != CAUSE_NONE);
   end

   // Combinational load path: pre-edge contents, zero when idle or faulting.
   always_comb begin
      if (mem_read && !access_fault) begin
         rdata = load_select(word_s, size, lane_s, load_unsigned);
      end else begin
         rdata = 32'h0000_0000;
      end
   end

   // Store enable and merged write word for the addressed lanes.
   always_comb begin
      store_en_s   = mem_write & ~access_fault;
      store_word_s = store_merge(word_s, wdata, size, lane_s);
   end

   // Memory array: clear every word on reset, otherwise commit legal stores.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_r[i[ADDR_BITS-1:0]] <= 32'h0000_0000;
         end
      end else if (store_en_s) begin
         mem_r[word_idx_s] <= store_word_s;
      end
   end

   // Capture is allowed when the register is empty or being cleared this edge.
   always_comb begin
      capture_s = access_fault & (fault_clear | ~fault_sticky);
   end

   // Sticky fault registers: first fault wins, clear and capture can coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_sticky <= 1'b0;
         fault_cause  <= CAUSE_NONE;
         fault_addr   <= 32'h0000_0000;
      end else if (capture_s) begin
         fault_sticky <= 1'b1;
         fault_cause  <= cause_s;
         fault_addr   <= addr;
      end else if (fault_clear) begin
         fault_sticky <= 1'b0;
         fault_cause  <= CAUSE_NONE;
         fault_addr   <= 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
// Directed self-checking bench for data_memory (256 words). Inputs change
// 1 time unit after each rising edge, and outputs are checked 2 units later,
// well before the next edge.
// ----------------------------------------------------------------------------
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        load_unsigned;
   logic        fault_clear;
   logic [31:0] rdata;
   logic        access_fault;
   logic        fault_sticky;
   logic [1:0]  fault_cause;
   logic [31:0] fault_addr;

   int n_checks;
   int n_errors;

   data_memory #(.DEPTH_WORDS(256), .ADDR_BITS(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .wdata         (wdata),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .size          (size),
      .load_unsigned (load_unsigned),
      .fault_clear   (fault_clear),
      .rdata         (rdata),
      .access_fault  (access_fault),
      .fault_sticky  (fault_sticky),
      .fault_cause   (fault_cause),
      .fault_addr    (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Apply one cycle of inputs and let the combinational outputs settle.
   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic clr,
                        input logic [31:0] a, input logic [31:0] wd);
      mem_read      = rd;
      mem_write     = wr;
      size          = sz;
      load_unsigned = uns;
      fault_clear   = clr;
      addr          = a;
      wdata         = wd;
      #2;
   endtask

   task automatic check_faults(input string tag, input logic st,
                               input logic [1:0] cause, input logic [31:0] fa);
      check_eq({tag, "_sticky"}, {31'd0, fault_sticky}, {31'd0, st});
      check_eq({tag, "_cause"},  {30'd0, fault_cause},  {30'd0, cause});
      check_eq({tag, "_addr"},   fault_addr, fa);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
      rst = 1'b0;

      // Reset state
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("reset", 1'b0, 2'b00, 32'h0);
      check_eq("idle_rdata", rdata, 32'h0);
      check_eq("idle_fault", {31'd0, access_fault}, 32'h0);

      // Word store then load
      drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF);
      check_eq("sw_fault", {31'd0, access_fault}, 32'h0);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
      check_eq("lw_10", rdata, 32'hDEADBEEF);
      check_eq("lw_10_fault", {31'd0, access_fault}, 32'h0);
      step();

      // Byte store uses only wdata[7:0]
      drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h11, 32'hFFFFFF80);
      step();
      drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h11, 32'h0);
      check_eq("lb_11", rdata, 32'hFFFFFF80);
      step();
      drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h11, 32'h0);
      check_eq("lbu_11", rdata, 32'h00000080);
      step();
      drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h12, 32'h0);
      check_eq("lh_12", rdata, 32'hFFFFDEAD);
      step();
      drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h10, 32'h0);
      check_eq("lhu_10", rdata, 32'h000080EF);
      step();
      drive(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h13, 32'h0);
      check_eq("lbu_13", rdata, 32'h000000DE);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
      check_eq("lw_10_merged", rdata, 32'hDEAD80EF);
      step();

      // Misaligned word store is suppressed and captured
      drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h22, 32'h12345678);
      check_eq("sw_22_fault", {31'd0, access_fault}, 32'h1);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h20, 32'h0);
      check_eq("lw_20_unchanged", rdata, 32'h0);
      check_faults("misalign", 1'b1, 2'b01, 32'h22);
      step();

      // Faulting load returns zero, later fault does not overwrite the first
      drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h4003, 32'h0);
      check_eq("badsize_fault", {31'd0, access_fault}, 32'h1);
      check_eq("badsize_rdata", rdata, 32'h0);
      step();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("hold", 1'b1, 2'b01, 32'h22);

      // Clear alone
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0);
      step();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("clear", 1'b0, 2'b00, 32'h0);

      // Clear together with an out-of-range load: new fault captured
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h400, 32'h0);
      check_eq("range_fault", {31'd0, access_fault}, 32'h1);
      step();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("range", 1'b1, 2'b10, 32'h400);

      // Priority: bad size beats out of range and misalignment
      drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 32'h4003, 32'h0);
      step();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("prio_size", 1'b1, 2'b11, 32'h4003);

      // Priority: out of range beats misalignment
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h402, 32'h0);
      step();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
      check_faults("prio_range", 1'b1, 2'b10, 32'h402);

      // Misaligned half load
      drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h13, 32'h0);
      check_eq("lh_13_fault", {31'd0, access_fault}, 32'h1);
      check_eq("lh_13_rdata", rdata, 32'h0);
      step();

      // Same-cycle load and store: no write-through
      drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 32'h30, 32'hA5A5A5A5);
      check_eq("rw_same_cycle", rdata, 32'h0);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h30, 32'h0);
      check_eq("rw_next_cycle", rdata, 32'hA5A5A5A5);
      step();

      // Reset mid-operation with a store requested and sticky set
      check_eq("pre_reset_sticky", {31'd0, fault_sticky}, 32'h1);
      rst = 1'b1;
      drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h40, 32'h11111111);
      step();
      rst = 1'b0;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h40, 32'h0);
      check_eq("rst_lw_40", rdata, 32'h0);
      check_faults("rst", 1'b0, 2'b00, 32'h0);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h10, 32'h0);
      check_eq("rst_lw_10", rdata, 32'h0);
      step();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h30, 32'h0);
      check_eq("rst_lw_30", rdata, 32'h0);
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
